// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph table for hex digits, segment bit order
// and the active-level helper used at the output registers.
package seg7_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_G = 6;
    localparam int unsigned SEG_W = SEG_G - SEG_A + 1;

    // Active-high glyphs, bit SEG_A = segment a ... bit SEG_G = segment g
    localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic to_level(input logic lit_bit, input logic active_low);
        return lit_bit ^ active_low;
    endfunction

endpackage

// File: rtl/hex_a_7seg.sv
// Combinational hex nibble to active-high 7-segment pattern decoder.
module hex_a_7seg
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = '0;
        seg[SEG_G:SEG_A] = SEG_HEX[nibble];
    end

endmodule

// File: rtl/seg7_multiplexor_n.sv
// N-digit time-multiplexed 7-segment driver with dead time, per-digit enable,
// decimal point, leading-zero blanking and frame-aligned input capture.
module seg7_multiplexor_n
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYCLES = 500,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic                  reloj,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] valor,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   en_digito,
    input  logic                  blank_lz,
    output logic [N_DIGITS-1:0]   anodo,
    output logic [6:0]            cSeg7,
    output logic                  dp_out,
    output logic                  frame_tick
);

    localparam int unsigned   CW       = $clog2(REFRESH_DIV);
    localparam int unsigned   IW       = $clog2(N_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic          POL      = (ACTIVE_LOW != 0);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  first_q;
    logic [4*N_DIGITS-1:0] valor_s;
    logic [N_DIGITS-1:0]   dp_s;
    logic [N_DIGITS-1:0]   en_s;
    logic                  blz_s;

    logic                  wrap;
    logic                  load;
    logic                  seen;
    logic [N_DIGITS-1:0]   blanked;
    logic [3:0]            cur_nib;
    logic [SEG_W-1:0]      seg_act;
    logic                  lit;
    logic [N_DIGITS-1:0]   an_act;
    logic [N_DIGITS-1:0]   an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    assign wrap = (cnt == CNT_LAST);
    // first_q makes the first clock after reset a load so a fresh frame starts at once
    assign load = first_q | (wrap & (idx == IDX_LAST));

    // Walk from the most significant digit down; a digit is blanked while no
    // enabled nonzero nibble has been seen at or above it. Digit 0 is never visited.
    always_comb begin
        seen    = 1'b0;
        blanked = '0;
        for (int unsigned k = 0; k < N_DIGITS - 1; k++) begin
            seen = seen | (en_s[N_DIGITS-1-k] & (valor_s[4*(N_DIGITS-1-k) +: 4] != 4'h0));
            blanked[N_DIGITS-1-k] = blz_s & ~seen;
        end
    end

    assign cur_nib = valor_s[4*idx +: 4];

    hex_a_7seg u_dec (
        .nibble (cur_nib),
        .seg    (seg_act)
    );

    always_comb begin
        lit     = (cnt >= CNT_DEAD) && en_s[idx] && !blanked[idx];
        an_act  = lit ? ({{(N_DIGITS-1){1'b0}}, 1'b1} << idx) : '0;
        an_nxt  = '0;
        seg_nxt = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            an_nxt[i] = to_level(an_act[i], POL);
        end
        for (int unsigned i = 0; i < SEG_W; i++) begin
            seg_nxt[i] = to_level(lit & seg_act[i], POL);
        end
        dp_nxt = to_level(lit & dp_s[idx], POL);
    end

    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            first_q    <= 1'b1;
            valor_s    <= '0;
            dp_s       <= '0;
            en_s       <= '0;
            blz_s      <= 1'b0;
            frame_tick <= 1'b0;
            anodo      <= {N_DIGITS{POL}};
            cSeg7      <= {7{POL}};
            dp_out     <= POL;
        end else begin
            first_q    <= 1'b0;
            frame_tick <= load;
            anodo      <= an_nxt;
            cSeg7      <= seg_nxt;
            dp_out     <= dp_nxt;
            if (wrap) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (load) begin
                valor_s <= valor;
                dp_s    <= dp_in;
                en_s    <= en_digito;
                blz_s   <= blank_lz;
            end
        end
    end

endmodule

// File: tb/tb_seg7_multiplexor_n.sv
// Bench for seg7_multiplexor_n: cycle-indexed reference model plus directed literal checks.
module tb_seg7_multiplexor_n;

    localparam int N = 4;
    localparam int R = 8;
    localparam int D = 2;

    logic        reloj = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] valor;
    logic [3:0]  dp_in;
    logic [3:0]  en_digito;
    logic        blank_lz;
    logic [3:0]  anodo;
    logic [6:0]  cSeg7;
    logic        dp_out;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    always #5 reloj = ~reloj;

    seg7_multiplexor_n #(
        .N_DIGITS    (4),
        .REFRESH_DIV (8),
        .DEAD_CYCLES (2),
        .ACTIVE_LOW  (1)
    ) dut (
        .reloj      (reloj),
        .rst_n      (rst_n),
        .valor      (valor),
        .dp_in      (dp_in),
        .en_digito  (en_digito),
        .blank_lz   (blank_lz),
        .anodo      (anodo),
        .cSeg7      (cSeg7),
        .dp_out     (dp_out),
        .frame_tick (frame_tick)
    );

    // Glyphs written out from the digit shapes, active-high
    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Model state: k = clock edges since reset release, plus captured frame inputs
    int          k;
    logic [15:0] m_val;
    logic [3:0]  m_en, m_dp;
    logic        m_blz;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_ft;
    int          ft_last = -1, ft_prev = -1;

    function automatic bit is_blank(input int d);
        if (!m_blz || d == 0) return 1'b0;
        for (int j = d; j < N; j++)
            if (m_en[j] && m_val[4*j +: 4] != 4'h0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit is_lit(input int c, input int d);
        return (c >= D) && m_en[d] && !is_blank(d);
    endfunction

    function automatic logic [3:0] exp_an(input int c, input int d);
        return is_lit(c, d) ? ~(4'b0001 << d) : 4'b1111;
    endfunction

    function automatic logic [6:0] exp_seg(input int c, input int d);
        return is_lit(c, d) ? ~glyph[m_val[4*d +: 4]] : 7'h7F;
    endfunction

    function automatic logic exp_dp(input int c, input int d);
        return (is_lit(c, d) && m_dp[d]) ? 1'b0 : 1'b1;
    endfunction

    function automatic bit is_load(input int kk);
        return (kk == 1) || (kk % (N * R) == 0);
    endfunction

    always @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            k     <= 0;
            m_val <= '0;
            m_en  <= '0;
            m_dp  <= '0;
            m_blz <= 1'b0;
            e_an  <= 4'hF;
            e_seg <= 7'h7F;
            e_dp  <= 1'b1;
            e_ft  <= 1'b0;
        end else begin
            e_an  <= exp_an(k % R, (k / R) % N);
            e_seg <= exp_seg(k % R, (k / R) % N);
            e_dp  <= exp_dp(k % R, (k / R) % N);
            e_ft  <= is_load(k + 1);
            if (is_load(k + 1)) begin
                m_val <= valor;
                m_en  <= en_digito;
                m_dp  <= dp_in;
                m_blz <= blank_lz;
            end
            k <= k + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t k=%0d: got %h expected %h", nm, $time, k, act, exp);
        end
    endtask

    always @(negedge reloj) begin
        if (chk_en) begin
            check("model_anodo", 32'(anodo), 32'(e_an));
            check("model_cSeg7", 32'(cSeg7), 32'(e_seg));
            check("model_dp", 32'(dp_out), 32'(e_dp));
            check("model_frame_tick", 32'(frame_tick), 32'(e_ft));
            if (frame_tick === 1'b1) begin
                ft_prev <= ft_last;
                ft_last <= k;
            end
        end
    end

    task automatic at(input int target);
        int guard = 0;
        while (k != target) begin
            @(negedge reloj);
            guard++;
            if (guard > 1000) begin
                checks++;
                errors++;
                $display("FAIL at_timeout: got k=%0d expected k=%0d", k, target);
                return;
            end
        end
    endtask

    task automatic lit_chk(input string nm, input logic [3:0] an, input logic [6:0] sg);
        check({nm, "_anodo"}, 32'(anodo), 32'(an));
        check({nm, "_seg"}, 32'(cSeg7), 32'(sg));
    endtask

    initial begin
        valor = 16'h1A3F; en_digito = 4'hF; dp_in = 4'h0; blank_lz = 1'b0;
        #1 rst_n = 1'b0;
        chk_en = 1;
        repeat (3) @(negedge reloj);
        check("rst_anodo", 32'(anodo), 32'h0000000F);
        check("rst_cSeg7", 32'(cSeg7), 32'h0000007F);
        check("rst_dp", 32'(dp_out), 32'h1);
        check("rst_ft", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;
        @(negedge reloj);
        check("ft_second_cycle", 32'(frame_tick), 32'h1);
        @(negedge reloj);
        check("ft_one_cycle", 32'(frame_tick), 32'h0);

        at(5);  lit_chk("scan_d0", 4'b1110, 7'h0E);
        at(9);  check("scan_dead", 32'(anodo), 32'hF);
        at(13); lit_chk("scan_d1", 4'b1101, 7'h30);
        at(21); lit_chk("scan_d2", 4'b1011, 7'h08);
        at(29); lit_chk("scan_d3", 4'b0111, 7'h79);

        valor = 16'h1111;
        at(32); check("ft_frame1", 32'(frame_tick), 32'h1);
        at(40); valor = 16'h2222;
        at(53); lit_chk("tear_d2", 4'b1011, 7'h79);
        at(61); lit_chk("tear_d3", 4'b0111, 7'h79);
        at(69); lit_chk("tear_next", 4'b1110, 7'h24);

        valor = 16'h0005; blank_lz = 1'b1;
        at(101); lit_chk("blz_d0", 4'b1110, 7'h12);
        at(109); check("blz_d1", 32'(anodo), 32'hF);
        at(117); check("blz_d2", 32'(anodo), 32'hF);
        at(125); check("blz_d3", 32'(anodo), 32'hF);
        valor = 16'h0000;
        at(133); lit_chk("blz_zero_d0", 4'b1110, 7'h40);
        at(141); check("blz_zero_d1", 32'(anodo), 32'hF);
        blank_lz = 1'b0;
        at(165); lit_chk("noblz_d0", 4'b1110, 7'h40);
        at(173); lit_chk("noblz_d1", 4'b1101, 7'h40);
        at(189); check("noblz_d3", 32'(anodo), 32'h7);

        valor = 16'h1A3F; en_digito = 4'b0101; dp_in = 4'b0100;
        at(197); check("en_d0", 32'(anodo), 32'hE); check("dp_d0", 32'(dp_out), 32'h1);
        at(205); check("en_d1_dark", 32'(anodo), 32'hF);
        at(210); check("dp_d2_dead", 32'(dp_out), 32'h1);
        at(213); lit_chk("en_d2", 4'b1011, 7'h08); check("dp_d2_lit", 32'(dp_out), 32'h0);
        at(221); check("en_d3_dark", 32'(anodo), 32'hF);

        valor = 16'h5003; en_digito = 4'b0111; dp_in = 4'h0; blank_lz = 1'b1;
        at(229); lit_chk("dis_nz_d0", 4'b1110, 7'h30);
        at(237); check("dis_nz_d1", 32'(anodo), 32'hF);
        at(245); check("dis_nz_d2", 32'(anodo), 32'hF);
        at(253); check("dis_nz_d3", 32'(anodo), 32'hF);

        valor = 16'h1A3F; en_digito = 4'hF; blank_lz = 1'b0;
        at(277); lit_chk("pre_rst_d2", 4'b1011, 7'h08);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_anodo", 32'(anodo), 32'hF);
        check("async_rst_cSeg7", 32'(cSeg7), 32'h7F);
        check("async_rst_dp", 32'(dp_out), 32'h1);
        repeat (2) @(negedge reloj);
        rst_n = 1'b1;
        @(negedge reloj);
        check("rerun_ft", 32'(frame_tick), 32'h1);
        at(5);  lit_chk("rerun_d0", 4'b1110, 7'h0E);
        at(13); lit_chk("rerun_d1", 4'b1101, 7'h30);
        at(70);
        check("frame_period", 32'(ft_last - ft_prev), 32'd32);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_multiplexor_n.md
# seg7_multiplexor_n

Parametrised N-digit time-multiplexed 7-segment display driver: the next generation of the 4-digit scanning submodule. Scans N hex digits onto shared segment lines with a programmable refresh divider. Adds inter-digit dead time against ghosting, per-digit enable and decimal point, and optional leading-zero blanking. Input values are captured at frame boundaries so a displayed frame never tears. Sits between the value-producing logic (counters, Gray/binary decoders) and the board's anode/segment pins.

## Interface
- N_DIGITS, 4, number of digits scanned (2..8)
- REFRESH_DIV, 50000, clock cycles per digit slot (≥ DEAD_CYCLES+2)
- DEAD_CYCLES, 500, cycles at the start of each slot with all anodes inactive (≥ 1)
- ACTIVE_LOW, 1, 1: segments/anodes/dp lit when driven 0 (common anode); 0: lit when driven 1
- reloj  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- valor  input  4*N_DIGITS  hex nibbles; nibble i = valor[4i+3:4i], digit 0 = least significant
- dp_in  input  N_DIGITS  decimal point request per digit
- en_digito  input  N_DIGITS  per-digit enable; 0 keeps that digit dark
- blank_lz  input  1  1 enables leading-zero blanking
- anodo  output  N_DIGITS  digit select, one-hot active (ACTIVE_LOW polarity)
- cSeg7  output  7  segments {g,f,e,d,c,b,a}; cSeg7[0] = a
- dp_out  output  1  decimal point segment
- frame_tick  output  1  one-cycle pulse at each frame boundary (shadow load)

## Operation
- Slot counter cnt counts 0..REFRESH_DIV-1, wraps to 0; digit index idx advances on each wrap, N_DIGITS-1 → 0.
- Shadow registers (valor_s, dp_s, en_s, blz_s) are loaded from the inputs on the cycle when cnt wraps and idx = N_DIGITS-1, and on the first clock after rst_n deasserts. frame_tick is high in the cycle following each load.
- Inputs changing mid-frame have no effect until the next load.
- Digit idx is lit when cnt ≥ DEAD_CYCLES and en_s[idx] = 1 and the digit is not blanked; otherwise all anodes are inactive and cSeg7/dp_out are inactive (all segments off).
- Leading-zero blanking (blz_s = 1): digit i ≥ 1 is blanked if nibbles i..N_DIGITS-1 are all 0. Digit 0 is never blanked. Disabled digits do not count as nonzero.
- Segment decode is hex 0–F: 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66, 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F, A = 0x77, b = 0x7C, C = 0x39, d = 0x5E, E = 0x79, F = 0x71, in active-high form. When ACTIVE_LOW = 1, segments and anodes are inverted at the output register.
- dp_out = dp_s[idx] while the digit is lit.

## Timing
- Reset values: cnt = 0, idx = 0, shadows = 0, frame_tick = 0. anodo, cSeg7 and dp_out are at their inactive level (all 1 when ACTIVE_LOW = 1).
- All outputs are registered. Outputs in cycle t+1 reflect (cnt, idx, shadows) in cycle t: one-cycle latency.
- Frame period is exactly N_DIGITS*REFRESH_DIV cycles. Lit time per digit is REFRESH_DIV-DEAD_CYCLES cycles.
- Never more than one anode active. Anodes never switch directly from one digit to another; at least DEAD_CYCLES dark cycles separate them.
- Reset mid-slot forces outputs inactive immediately (asynchronously). Scanning restarts at idx = 0, cnt = 0.
- An input change in the same cycle as a shadow load is captured (the load samples the current input).

## Structure
- Package seg7_pkg: hex-to-segment constant array SEG_HEX[16], segment bit-order constants, helper function for the active-level inversion.
- Sub-module hex_a_7seg: combinational nibble → 7-bit active-high segment decoder using seg7_pkg.
- Top level holds the prescaler, index, shadow registers, blanking logic and output registers.

## Test plan
Parameters for all scenarios: N_DIGITS = 4, REFRESH_DIV = 8, DEAD_CYCLES = 2, ACTIVE_LOW = 1.
- Reset: hold rst_n = 0 → anodo = 4'b1111, cSeg7 = 7'h7F, dp_out = 1, frame_tick = 0. Release → frame_tick pulses on the second cycle.
- Scan: valor = 16'h1A3F, en = 4'hF → cycle by cycle:
  - anodo: 1110 / 1101 / 1011 / 0111, each active 6 cycles, 2 dark cycles between.
  - cSeg7: ~0x71, ~0x4F, ~0x77, ~0x06.
  - Frame period: 32 cycles.
- Tearing: change valor from 16'h1111 to 16'h2222 mid-frame → the remaining digits of that frame still show 1. All digits show 2 after the next frame_tick.
- Leading-zero blanking: valor = 16'h0005, blank_lz = 1 → only digit 0 is lit (~0x6D). valor = 16'h0000 → digit 0 shows "0". blank_lz = 0 → all four digits lit.
- Enable and dp: en = 4'b0101, dp_in = 4'b0100 → digits 1 and 3 are never lit. dp_out = 0 only during digit 2's lit window.
- Reset mid-slot: assert rst_n = 0 while digit 2 is lit → anodo = 1111 in the same cycle. After release, scanning resumes at digit 0.
